// File: rtl/add_subt_sliced_pkg.sv
// Shared parameters, state encoding and helpers for the sliced adder/subtractor.
package add_subt_sliced_pkg;

  localparam int unsigned W_DEF     = 32;
  localparam int unsigned SLICE_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_FLAGS = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Status flags loaded together with the result.
  typedef struct packed {
    logic ovf;
    logic zero;
  } flags_t;

  // Counter width able to address n slices (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_subt_sliced_if.sv
// Controller-facing handshake and data bus of the sliced adder/subtractor.
interface add_subt_sliced_if #(
  parameter int unsigned W = 32
);
  logic         beg_add_subt;
  logic         ack_add_subt;
  logic         add_subt;
  logic [W-1:0] Data_X;
  logic [W-1:0] Data_Y;
  logic         ready_add_subt;
  logic         busy;
  logic [W-1:0] Data_Result;
  logic         overflow_flag;
  logic         zero_flag;

  modport master (
    output beg_add_subt, ack_add_subt, add_subt, Data_X, Data_Y,
    input  ready_add_subt, busy, Data_Result, overflow_flag, zero_flag
  );

  modport slave (
    input  beg_add_subt, ack_add_subt, add_subt, Data_X, Data_Y,
    output ready_add_subt, busy, Data_Result, overflow_flag, zero_flag
  );
endinterface

// File: rtl/add_subt_sliced_add_slice.sv
// SLICE-bit ripple adder reused for every slice of the operands.
module add_slice #(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  localparam int unsigned SW = SLICE + 1;

  // Sum with carry-out in the extra top bit.
  always_comb begin
    {cout, sum} = SW'(a) + SW'(b) + SW'(cin);
  end

endmodule

// File: rtl/add_subt_sliced.sv
// Multi-cycle add/subtract: one SLICE-bit adder walks the operands LSB first.
module add_subt_sliced
  import add_subt_sliced_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned SLICE = SLICE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  add_subt_sliced_if.slave  bus
);

  localparam int unsigned      N_SLICE  = W / SLICE;
  localparam int unsigned      CNT_W    = cnt_width(N_SLICE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SLICE - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     x_q, x_d;
  logic [W-1:0]     y_q, y_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [W-1:0]     result_q, result_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  flags_t           flags_q, flags_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE-1:0] s_slice;
  logic             c_out;

  // Pick the operand slice addressed by the counter.
  always_comb begin
    a_slice = x_q[int'(cnt_q) * SLICE +: SLICE];
    b_slice = y_q[int'(cnt_q) * SLICE +: SLICE];
  end

  add_slice #(
    .SLICE (SLICE)
  ) u_add_slice (
    .a    (a_slice),
    .b    (b_slice),
    .cin  (carry_q),
    .sum  (s_slice),
    .cout (c_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; beg only counts in IDLE, ack only in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.beg_add_subt) state_d = ST_EXEC;
      ST_EXEC:  if (cnt_q == CNT_LAST) state_d = ST_FLAGS;
      ST_FLAGS: state_d = ST_DONE;
      ST_DONE:  if (bus.ack_add_subt) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and status next values per state.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    sum_d    = sum_q;
    result_d = result_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    flags_d  = flags_q;
    ready_d  = (state_q == ST_DONE);
    busy_d   = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (bus.beg_add_subt) begin
          // Subtract as X + ~Y + 1.
          x_d     = bus.Data_X;
          y_d     = bus.add_subt ? ~bus.Data_Y : bus.Data_Y;
          carry_d = bus.add_subt;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      ST_EXEC: begin
        sum_d[int'(cnt_q) * SLICE +: SLICE] = s_slice;
        carry_d = c_out;
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FLAGS: begin
        result_d     = sum_q;
        flags_d.zero = (sum_q == '0);
        flags_d.ovf  = (x_q[W-1] == y_q[W-1]) && (sum_q[W-1] != x_q[W-1]);
      end
      default: begin
      end
    endcase
  end

  // Datapath and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      sum_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      flags_q  <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      flags_q  <= flags_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.ready_add_subt = ready_q;
  assign bus.busy           = busy_q;
  assign bus.Data_Result    = result_q;
  assign bus.overflow_flag  = flags_q.ovf;
  assign bus.zero_flag      = flags_q.zero;

endmodule
